// File: rtl/compositor_pkg.sv
// Shared types and constants for the BCD-to-binary compositor
// and its decimal-entry helpers.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIM
  } state_t;

  localparam int         N_DIG   = 5;
  localparam int         ACC_W   = 17;
  localparam int         IDX_W   = 3;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/compositor_mul10_soma.sv
// Combinational decimal shift-in step: soma = acc*10 + d, truncated to ACC_W bits.
module mul10_soma
  import compositor_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       d,
  output logic [ACC_W-1:0] soma
);

  always_comb begin
    soma = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, d};
  end

endmodule

// File: rtl/compositor.sv
// Five-digit signed BCD to W-bit two's-complement converter, one digit per clock,
// with start/busy/done handshake and saturating range check.
module compositor
  import compositor_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   dezena_milhar,
  input  logic [3:0]   milhar,
  input  logic [3:0]   centena,
  input  logic [3:0]   dezena,
  input  logic [3:0]   unidade,
  input  logic         sinal,
  output logic [W-1:0] numero,
  output logic         done,
  output logic         erro,
  output logic         busy
);

  localparam logic [ACC_W-1:0] MAX_POS = ACC_W'((1 << (W-1)) - 1);
  localparam logic [ACC_W-1:0] MAX_NEG = ACC_W'(1 << (W-1));

  state_t                  state_q, state_d;
  logic [N_DIG-1:0][3:0]   dig_q, dig_d;
  logic                    sinal_q, sinal_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    inval_q, inval_d;
  logic [W-1:0]            numero_q, numero_d;
  logic                    done_q, done_d;
  logic                    erro_q, erro_d;

  logic [3:0]              dig_cur;
  logic [ACC_W-1:0]        acc_next;
  logic [ACC_W-1:0]        acc_neg;

  assign dig_cur = dig_q[idx_q];
  assign acc_neg = -acc_q;

  mul10_soma u_mul10_soma (
    .acc  (acc_q),
    .d    (dig_cur),
    .soma (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    sinal_d  = sinal_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    inval_d  = inval_q;
    numero_d = numero_q;
    erro_d   = erro_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Index 0 holds the most significant digit so accumulation runs MSD first.
          dig_d   = {unidade, dezena, centena, milhar, dezena_milhar};
          sinal_d = sinal;
          acc_d   = '0;
          idx_d   = '0;
          inval_d = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        if (dig_cur > BCD_MAX) begin
          inval_d = 1'b1;
        end
        if (idx_q == IDX_W'(N_DIG-1)) begin
          state_d = FIM;
        end
      end
      FIM: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (inval_q) begin
          numero_d = '0;
          erro_d   = 1'b1;
        end else if (!sinal_q && (acc_q > MAX_POS)) begin
          numero_d = MAX_POS[W-1:0];
          erro_d   = 1'b1;
        end else if (sinal_q && (acc_q > MAX_NEG)) begin
          numero_d = {1'b1, {(W-1){1'b0}}};
          erro_d   = 1'b1;
        end else begin
          numero_d = sinal_q ? acc_neg[W-1:0] : acc_q[W-1:0];
          erro_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      sinal_q  <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      inval_q  <= 1'b0;
      numero_q <= '0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      sinal_q  <= sinal_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      inval_q  <= inval_d;
      numero_q <= numero_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
    end
  end

  assign numero = numero_q;
  assign done   = done_q;
  assign erro   = erro_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_compositor.sv
// Scoreboard bench for compositor: stimulus pushes expected results, a negedge
// monitor pops and compares whenever done pulses.
module tb_compositor;

  localparam int W = 16;
  localparam int MAX_POS = (1 << (W-1)) - 1;
  localparam int MAX_NEG = (1 << (W-1));

  typedef struct {
    logic [W-1:0] num;
    logic         erro;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   dm = '0, mi = '0, ce = '0, de = '0, un = '0;
  logic         sinal = 1'b0;
  logic [W-1:0] numero;
  logic         done, erro, busy;

  int   n_compared = 0;
  int   n_mismatch = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  compositor #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dezena_milhar (dm),
    .milhar        (mi),
    .centena       (ce),
    .dezena        (de),
    .unidade       (un),
    .sinal         (sinal),
    .numero        (numero),
    .done          (done),
    .erro          (erro),
    .busy          (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal value from the digits, then the sign/range rules.
  function automatic void ref_model(input logic [3:0] d4, d3, d2, d1, d0, input logic s,
                                    output logic [W-1:0] num, output logic e);
    int val;
    val = int'(d4)*10000 + int'(d3)*1000 + int'(d2)*100 + int'(d1)*10 + int'(d0);
    if (d4 > 9 || d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) begin
      num = '0; e = 1'b1;
    end else if (!s && val > MAX_POS) begin
      num = W'(MAX_POS); e = 1'b1;
    end else if (s && val > MAX_NEG) begin
      num = W'(-MAX_NEG); e = 1'b1;
    end else begin
      num = s ? W'(-val) : W'(val); e = 1'b0;
    end
  endfunction

  function automatic void push_expected(input logic [3:0] d4, d3, d2, d1, d0, input logic s);
    exp_t x;
    ref_model(d4, d3, d2, d1, d0, s, x.num, x.erro);
    x.cyc = cyc + 7;
    sb.push_back(x);
  endfunction

  function automatic logic [3:0] rand_dig();
    if ($urandom_range(0, 15) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("numero", 32'(numero), 32'(mon_e.num));
        checkOutput("erro", 32'(erro), 32'(mon_e.erro));
        checkOutput("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((busy || sb.size() != 0) && t < 100);
    if (t >= 100) checkOutput("idle_timeout", 32'(sb.size()) + 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] d4, d3, d2, d1, d0, input logic s, input bit chk_busy);
    wait_idle();
    dm = d4; mi = d3; ce = d2; de = d1; un = d0; sinal = s;
    start = 1'b1;
    push_expected(d4, d3, d2, d1, d0, s);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dm = rand_dig(); mi = rand_dig(); ce = rand_dig(); de = rand_dig(); un = rand_dig();
    sinal = ~s;
    if (chk_busy) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput("busy_high", 32'(busy), 32'd1);
        @(negedge clk);
      end
      checkOutput("busy_low_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    #12;
    checkOutput("rst_numero", 32'(numero), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_erro", 32'(erro), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 2, 3, 4, 5, 0, 1);
    applyStimulus(3, 2, 7, 6, 8, 1, 0);
    applyStimulus(3, 2, 7, 6, 8, 0, 0);
    applyStimulus(3, 2, 7, 6, 7, 0, 0);
    applyStimulus(3, 2, 7, 6, 9, 1, 0);
    applyStimulus(9, 9, 9, 9, 9, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 2, 4'hA, 4, 5, 0, 1);
    applyStimulus(0, 0, 0, 0, 4'hF, 1, 0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(rand_dig(), rand_dig(), rand_dig(), rand_dig(), rand_dig(), 1'($urandom_range(0, 1)), 0);
    end

    // start held high with digits changing each cycle: acceptance every 7 edges.
    wait_idle();
    for (int i = 0; i < 21; i++) begin
      dm = rand_dig(); mi = rand_dig(); ce = rand_dig(); de = rand_dig(); un = rand_dig();
      sinal = 1'($urandom_range(0, 1));
      start = 1'b1;
      if (i % 7 == 0) push_expected(dm, mi, ce, de, un, sinal);
      @(negedge clk);
    end
    start = 1'b0;

    // Abort in the third CONV cycle, then convert -42.
    wait_idle();
    dm = 1; mi = 1; ce = 1; de = 1; un = 1; sinal = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_numero", 32'(numero), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_erro", 32'(erro), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 4, 2, 1, 1);

    wait_idle();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
